// File: rtl/adc_scale_avg_pkg.sv
// ----------------------------------------------------------------------------
// adc_scale_avg_pkg : default widths and board calibration constants
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package adc_scale_avg_pkg;

  localparam int DEF_NUM_CH   = 2;
  localparam int DEF_IN_W     = 16;
  localparam int DEF_COEF_W   = 16;
  localparam int DEF_FRAC     = 16;
  localparam int DEF_OUT_W    = 16;
  localparam int DEF_AVG_LOG2 = 2;

  // Standard calibration set, gains in Q16
  localparam int CAL_IBRD_GAIN   = -262;
  localparam int CAL_IBRD_OFFSET = 20;
  localparam int CAL_VGAP_GAIN   = -1835;
  localparam int CAL_VGAP_OFFSET = 0;

  function automatic int acc_width(input int out_w, input int avg_log2);
    return out_w + avg_log2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/adc_ch_scale.sv
// ----------------------------------------------------------------------------
// adc_ch_scale : single-channel 2-stage gain / round / offset / saturate pipe
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module adc_ch_scale
  import adc_scale_avg_pkg::*;
#(
  parameter int IN_W   = DEF_IN_W,
  parameter int COEF_W = DEF_COEF_W,
  parameter int FRAC   = DEF_FRAC,
  parameter int OUT_W  = DEF_OUT_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic [IN_W-1:0]   x_i,
  input  logic [COEF_W-1:0] gain_i,
  input  logic [OUT_W-1:0]  offset_i,
  output logic              valid_o,
  output logic [OUT_W-1:0]  y_o,
  output logic              sat_o
);

  localparam int PW = IN_W + COEF_W + 1;
  localparam int SW = PW + 2;
  localparam logic signed [SW-1:0] RND  = (FRAC > 0) ? (SW'(1) <<< (FRAC - 1)) : '0;
  localparam logic signed [SW-1:0] MAXV = (SW'(1) <<< (OUT_W - 1)) - SW'(1);
  localparam logic signed [SW-1:0] MINV = -(SW'(1) <<< (OUT_W - 1));

  logic signed [PW-1:0]    prod_q, prod_d;
  logic signed [OUT_W-1:0] off_q;
  logic                    vld1_q;
  logic                    vld2_q;
  logic [OUT_W-1:0]        y_q, y_d;
  logic                    sat_q, sat_d;
  logic signed [SW-1:0]    w_sum;

  always_comb begin
    prod_d = PW'($signed(x_i)) * PW'($signed(gain_i));
  end

  // Offset travels with its product so coefficient changes never hit in-flight samples
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld1_q <= 1'b0;
      prod_q <= '0;
      off_q  <= '0;
    end else begin
      vld1_q <= valid_i;
      if (valid_i) begin
        prod_q <= prod_d;
        off_q  <= $signed(offset_i);
      end
    end
  end

  always_comb begin
    w_sum = ((SW'(prod_q) + RND) >>> FRAC) + SW'(off_q);
    y_d   = w_sum[OUT_W-1:0];
    sat_d = 1'b0;
    if (w_sum > MAXV) begin
      y_d   = MAXV[OUT_W-1:0];
      sat_d = 1'b1;
    end else if (w_sum < MINV) begin
      y_d   = MINV[OUT_W-1:0];
      sat_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld2_q <= 1'b0;
      y_q    <= '0;
      sat_q  <= 1'b0;
    end else begin
      vld2_q <= vld1_q;
      if (vld1_q) begin
        y_q   <= y_d;
        sat_q <= sat_d;
      end
    end
  end

  assign valid_o = vld2_q;
  assign y_o     = y_q;
  assign sat_o   = sat_q;

endmodule

`default_nettype wire

// File: rtl/adc_scale_avg.sv
// ----------------------------------------------------------------------------
// adc_scale_avg : multi-channel ADC scaler with windowed averager and sticky saturation flags
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module adc_scale_avg
  import adc_scale_avg_pkg::*;
#(
  parameter int NUM_CH   = DEF_NUM_CH,
  parameter int IN_W     = DEF_IN_W,
  parameter int COEF_W   = DEF_COEF_W,
  parameter int FRAC     = DEF_FRAC,
  parameter int OUT_W    = DEF_OUT_W,
  parameter int AVG_LOG2 = DEF_AVG_LOG2
) (
  input  logic                      ad_clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [NUM_CH*IN_W-1:0]    in_data,
  input  logic [NUM_CH*COEF_W-1:0]  gain,
  input  logic [NUM_CH*OUT_W-1:0]   offset,
  input  logic                      avg_clr,
  input  logic                      sat_clr,
  output logic                      scaled_valid,
  output logic [NUM_CH*OUT_W-1:0]   scaled_data,
  output logic                      avg_valid,
  output logic [NUM_CH*OUT_W-1:0]   avg_data,
  output logic [NUM_CH-1:0]         sat_flag
);

  logic [NUM_CH-1:0] w_ch_vld;
  logic [NUM_CH-1:0] w_ch_sat;
  logic [NUM_CH-1:0] w_sat_evt;
  logic [NUM_CH-1:0] sat_flag_q, sat_flag_d;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    adc_ch_scale #(
      .IN_W   (IN_W),
      .COEF_W (COEF_W),
      .FRAC   (FRAC),
      .OUT_W  (OUT_W)
    ) u_scale (
      .clk_i    (ad_clk),
      .rst_i    (rst),
      .valid_i  (in_valid),
      .x_i      (in_data[ch*IN_W +: IN_W]),
      .gain_i   (gain[ch*COEF_W +: COEF_W]),
      .offset_i (offset[ch*OUT_W +: OUT_W]),
      .valid_o  (w_ch_vld[ch]),
      .y_o      (scaled_data[ch*OUT_W +: OUT_W]),
      .sat_o    (w_ch_sat[ch])
    );
  end

  assign scaled_valid = &w_ch_vld;

  // Flag shows in the strobe cycle; a clear in that same cycle cannot drop the new event
  assign w_sat_evt = scaled_valid ? w_ch_sat : '0;
  assign sat_flag  = sat_flag_q | w_sat_evt;

  always_comb begin
    sat_flag_d = (sat_clr ? '0 : sat_flag_q) | w_sat_evt;
  end

  always_ff @(posedge ad_clk) begin
    if (rst) sat_flag_q <= '0;
    else     sat_flag_q <= sat_flag_d;
  end

  if (AVG_LOG2 == 0) begin : g_avg_bypass
    logic                    avg_valid_q;
    logic [NUM_CH*OUT_W-1:0] avg_data_q;

    always_ff @(posedge ad_clk) begin
      if (rst) begin
        avg_valid_q <= 1'b0;
        avg_data_q  <= '0;
      end else begin
        avg_valid_q <= scaled_valid;
        avg_data_q  <= scaled_data;
      end
    end

    assign avg_valid = avg_valid_q;
    assign avg_data  = avg_data_q;
  end else begin : g_avg
    localparam int AW = acc_width(OUT_W, AVG_LOG2);

    logic [AVG_LOG2-1:0] cnt_q, cnt_d, w_cnt_base;
    logic                w_last;
    logic                avg_valid_q;

    // A clear coinciding with a sample makes that sample the first of the new window
    always_comb begin
      w_cnt_base = avg_clr ? '0 : cnt_q;
      w_last     = scaled_valid && (w_cnt_base == {AVG_LOG2{1'b1}});
      cnt_d      = w_cnt_base;
      if (scaled_valid) cnt_d = w_cnt_base + AVG_LOG2'(1);
    end

    always_ff @(posedge ad_clk) begin
      if (rst) begin
        cnt_q       <= '0;
        avg_valid_q <= 1'b0;
      end else begin
        cnt_q       <= cnt_d;
        avg_valid_q <= w_last;
      end
    end

    assign avg_valid = avg_valid_q;

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_acc
      logic signed [AW-1:0] acc_q, acc_d, w_base, w_sum;
      logic [OUT_W-1:0]     avg_q;

      always_comb begin
        w_base = avg_clr ? '0 : acc_q;
        w_sum  = w_base + AW'($signed(scaled_data[ch*OUT_W +: OUT_W]));
        acc_d  = w_base;
        if (scaled_valid) acc_d = w_last ? '0 : w_sum;
      end

      // Upper OUT_W bits of the total are the floor of the mean
      always_ff @(posedge ad_clk) begin
        if (rst) begin
          acc_q <= '0;
          avg_q <= '0;
        end else begin
          acc_q <= acc_d;
          if (w_last) avg_q <= w_sum[AW-1:AVG_LOG2];
        end
      end

      assign avg_data[ch*OUT_W +: OUT_W] = avg_q;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_adc_scale_avg.sv
// ----------------------------------------------------------------------------
// tb_adc_scale_avg : directed self-checking bench for adc_scale_avg
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_adc_scale_avg;
  import adc_scale_avg_pkg::*;

  logic        ad_clk   = 1'b0;
  logic        rst      = 1'b1;
  logic        in_valid = 1'b0;
  logic        avg_clr  = 1'b0;
  logic        sat_clr  = 1'b0;
  logic [31:0] in_data  = '0;
  logic [31:0] gain     = '0;
  logic [31:0] offset   = '0;

  logic        scaled_valid, avg_valid;
  logic [31:0] scaled_data, avg_data;
  logic [1:0]  sat_flag;
  logic        b_scaled_valid, b_avg_valid;
  logic [31:0] b_scaled_data, b_avg_data;
  logic [1:0]  b_sat_flag;

  int total = 0;
  int bad   = 0;

  int v0[8] = '{10, 11, 12, 14, 8, 8, 8, 8};
  int v1[8] = '{-1, -2, -2, -2, -8, -8, -8, -8};

  adc_scale_avg dut (
    .ad_clk(ad_clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .gain(gain), .offset(offset), .avg_clr(avg_clr), .sat_clr(sat_clr),
    .scaled_valid(scaled_valid), .scaled_data(scaled_data),
    .avg_valid(avg_valid), .avg_data(avg_data), .sat_flag(sat_flag)
  );

  adc_scale_avg #(.AVG_LOG2(0)) dut_bypass (
    .ad_clk(ad_clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .gain(gain), .offset(offset), .avg_clr(avg_clr), .sat_clr(sat_clr),
    .scaled_valid(b_scaled_valid), .scaled_data(b_scaled_data),
    .avg_valid(b_avg_valid), .avg_data(b_avg_data), .sat_flag(b_sat_flag)
  );

  always #5 ad_clk = ~ad_clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge ad_clk);
    #1;
  endtask

  task automatic drive(input int x0, input int g0, input int o0,
                       input int x1, input int g1, input int o1);
    in_data  = {x1[15:0], x0[15:0]};
    gain     = {g1[15:0], g0[15:0]};
    offset   = {o1[15:0], o0[15:0]};
    in_valid = 1'b1;
  endtask

  function automatic logic signed [31:0] lo(input logic [31:0] v);
    return 32'($signed(v[15:0]));
  endfunction

  function automatic logic signed [31:0] hi(input logic [31:0] v);
    return 32'($signed(v[31:16]));
  endfunction

  initial begin
    // Reset state
    step();
    step();
    check("rst_sv",   scaled_valid, 0);
    check("rst_av",   avg_valid, 0);
    check("rst_sd",   scaled_data, 0);
    check("rst_ad",   avg_data, 0);
    check("rst_sat",  sat_flag, 0);
    check("rst_bav",  b_avg_valid, 0);
    rst = 1'b0;
    step();

    // Calibration constants, 2-cycle latency
    drive(1000, CAL_IBRD_GAIN, CAL_IBRD_OFFSET, -1000, CAL_VGAP_GAIN, CAL_VGAP_OFFSET);
    step();
    in_valid = 1'b0;
    check("lat1_sv", scaled_valid, 0);
    step();
    check("cal_sv",  scaled_valid, 1);
    check("cal_ch0", lo(scaled_data), 16);
    check("cal_ch1", hi(scaled_data), 28);
    check("cal_sat", sat_flag, 0);
    step();
    check("strobe_len", scaled_valid, 0);

    // Back-to-back samples with a coefficient change on the second
    drive(1000, -262, 20, 0, -1835, 0);
    step();
    drive(1000, 0, 5, 0, 0, 0);
    step();
    in_valid = 1'b0;
    check("b2b0_sv",  scaled_valid, 1);
    check("b2b0_ch0", lo(scaled_data), 16);
    check("b2b0_ch1", hi(scaled_data), 0);
    step();
    check("b2b1_sv",  scaled_valid, 1);
    check("b2b1_ch0", lo(scaled_data), 5);

    // Positive and negative saturation, sticky behaviour
    drive(32767, 32767, 32767, -32768, 32767, -32768);
    step();
    in_valid = 1'b0;
    step();
    check("sat_ch0", lo(scaled_data), 32767);
    check("sat_ch1", hi(scaled_data), -32768);
    check("sat_flag", sat_flag, 3);
    step();
    step();
    check("sat_hold", sat_flag, 3);
    sat_clr = 1'b1;
    step();
    sat_clr = 1'b0;
    check("sat_clr", sat_flag, 0);
    drive(32767, 32767, 32767, 0, 0, 0);
    step();
    in_valid = 1'b0;
    step();
    check("sat_evt", sat_flag, 1);
    sat_clr = 1'b1;
    step();
    sat_clr = 1'b0;
    check("sat_coinc", sat_flag, 1);

    avg_clr = 1'b1;
    step();
    avg_clr = 1'b0;

    // Continuous averaging: two windows, plus the unaveraged variant
    for (int s = 0; s < 12; s++) begin
      if (s < 8) drive(0, 0, v0[s], 0, 0, v1[s]);
      else       in_valid = 1'b0;
      step();
      check("avg1_sv", scaled_valid, (s >= 1 && s <= 8));
      check("avg1_bsv", b_scaled_valid, (s >= 1 && s <= 8));
      if (s >= 1 && s <= 8) begin
        check("avg1_sd0", lo(scaled_data), v0[s-1]);
        check("avg1_bsd1", hi(b_scaled_data), v1[s-1]);
      end
      check("avg1_av", avg_valid, (s == 5 || s == 9));
      if (s == 5) begin
        check("avg1_w0c0", lo(avg_data), 11);
        check("avg1_w0c1", hi(avg_data), -2);
      end
      if (s == 9) begin
        check("avg1_w1c0", lo(avg_data), 8);
        check("avg1_w1c1", hi(avg_data), -8);
      end
      check("byp_av", b_avg_valid, (s >= 2 && s <= 9));
      if (s >= 2 && s <= 9) begin
        check("byp_c0", lo(b_avg_data), v0[s-2]);
        check("byp_c1", hi(b_avg_data), v1[s-2]);
      end
    end

    // avg_clr with no sample in flight discards the partial window
    for (int s = 0; s < 12; s++) begin
      if (s < 2)                drive(0, 0, 100, 0, 0, 100);
      else if (s >= 5 && s < 9) drive(0, 0, 8, 0, 0, 8);
      else                      in_valid = 1'b0;
      avg_clr = (s == 4);
      step();
      check("clr1_av", avg_valid, (s == 10));
      if (s == 10) begin
        check("clr1_c0", lo(avg_data), 8);
        check("clr1_c1", hi(avg_data), 8);
      end
    end
    avg_clr = 1'b0;

    // avg_clr coincident with the 3rd scaled sample
    for (int s = 0; s < 10; s++) begin
      if (s < 2)      drive(0, 0, 100, 0, 0, 100);
      else if (s < 6) drive(0, 0, 8, 0, 0, -6);
      else            in_valid = 1'b0;
      avg_clr = (s == 4);
      step();
      check("clr2_av", avg_valid, (s == 7));
      if (s == 7) begin
        check("clr2_c0", lo(avg_data), 8);
        check("clr2_c1", hi(avg_data), -6);
      end
    end
    avg_clr = 1'b0;

    // Reset mid-window with samples in both pipeline stages
    for (int s = 0; s < 4; s++) begin
      drive(0, 0, 40, 0, 0, -4);
      step();
    end
    rst = 1'b1;
    drive(32767, 32767, 32767, 0, 0, 0);
    step();
    check("mrst_sv",  scaled_valid, 0);
    check("mrst_av",  avg_valid, 0);
    check("mrst_sd",  scaled_data, 0);
    check("mrst_ad",  avg_data, 0);
    check("mrst_sat", sat_flag, 0);
    check("mrst_bav", b_avg_valid, 0);
    rst      = 1'b0;
    in_valid = 1'b0;
    step();
    check("post_sv", scaled_valid, 0);
    check("post_av", avg_valid, 0);
    step();
    check("post2_sv", scaled_valid, 0);

    for (int s = 0; s < 8; s++) begin
      if (s < 4) drive(0, 0, 20, 0, 0, -4);
      else       in_valid = 1'b0;
      step();
      check("new_av", avg_valid, (s == 5));
      if (s == 5) begin
        check("new_c0", lo(avg_data), 20);
        check("new_c1", hi(avg_data), -4);
      end
    end
    check("end_sat", sat_flag, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/adc_scale_avg.md
ADC_SCALE_AVG -- requirements
Module: adc_scale_avg

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- NUM_CH, 2, number of ADC channels sampled together.
- IN_W, 16, signed width of raw sample (mV).
- COEF_W, 16, signed width of per-channel gain.
- FRAC, 16, fractional bits of gain.
- OUT_W, 16, signed width of real-value output.
- AVG_LOG2, 2, log2 of averaging window; 0 = no averaging.
REQ-002 Ports (name, direction, width, meaning), one per line:
- ad_clk, in, 1, sole clock.
- rst, in, 1, synchronous active-high reset.
- in_valid, in, 1, all channels of in_data valid this cycle.
- in_data, in, NUM_CH*IN_W, raw signed samples; ch0 in LSBs.
- gain, in, NUM_CH*COEF_W, per-channel signed gain, Q(FRAC).
- offset, in, NUM_CH*OUT_W, per-channel signed offset in output units.
- avg_clr, in, 1, discard partial average window.
- sat_clr, in, 1, clear sticky saturation flags.
- scaled_valid, out, 1, one-cycle strobe for scaled_data.
- scaled_data, out, NUM_CH*OUT_W, per-sample real values.
- avg_valid, out, 1, one-cycle strobe for avg_data.
- avg_data, out, NUM_CH*OUT_W, windowed mean of real values.
- sat_flag, out, NUM_CH, sticky per-channel saturation indicator.
REQ-003 The clock and reset SHALL be ad_clk, one clock domain, with rst synchronous and active-high.

Function
REQ-004 The per-channel scaled value SHALL be y = sat_OUT_W(((x*gain + 2^(FRAC-1)) >>> FRAC) + offset), computed at full width (IN_W+COEF_W+1 bits minimum); >>> is arithmetic, so rounding is half-up.
REQ-005 Saturation SHALL clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1] and set that channel's sat_flag in the same cycle scaled_valid asserts.
REQ-006 Scaling SHALL be a 2-stage pipeline: stage 1 registers the products and stage 2 registers round/offset/saturate. scaled_valid SHALL assert exactly 2 cycles after the accepting in_valid.
REQ-007 in_valid SHALL be accepted every cycle (no backpressure); back-to-back samples SHALL produce back-to-back scaled_valid.
REQ-008 gain and offset SHALL be sampled together with in_data on in_valid. A coefficient change applies from the next accepted sample, never to a sample already in flight.
REQ-009 The averager SHALL keep a per-channel accumulator of OUT_W+AVG_LOG2 bits and a shared window counter of AVG_LOG2 bits.
REQ-010 The averager SHALL add each scaled sample. On the 2^AVG_LOG2-th sample it SHALL register avg_data = acc_total >>> AVG_LOG2 (floor), pulse avg_valid for 1 cycle (1 cycle after that scaled_valid), and restart the window.
REQ-011 When AVG_LOG2 = 0, avg_data/avg_valid SHALL equal scaled_data/scaled_valid delayed by 1 cycle.
REQ-012 avg_clr SHALL zero the accumulators and counter. If avg_clr coincides with scaled_valid, that sample SHALL become the first of the new window and no avg_valid results from the old window.
REQ-013 sat_clr SHALL clear sat_flag. If it coincides with a new saturation event, the flag SHALL end set.
REQ-014 The window counter SHALL wrap from 2^AVG_LOG2-1 to 0 with no lost or double-counted sample.

Reset
REQ-015 rst SHALL clear all pipeline valids, accumulators, the counter, scaled_data, avg_data and sat_flag to 0 on the next ad_clk edge. In-flight samples SHALL be discarded, including mid-window.
REQ-016 No output strobe SHALL assert in the cycle following rst deassertion unless in_valid was accepted 2 cycles earlier, which is impossible since inputs are ignored while rst is high.

Structure
REQ-017 A shared package SHALL hold the default widths, FRAC, and the standard calibration constants: board-current gain -262 with offset 20, and gap-voltage gain -1835 with offset 0, for FRAC=16.
REQ-018 One sub-module, adc_ch_scale (the single-channel 2-stage scale/saturate pipe), SHALL be instantiated NUM_CH times; the averager and flags SHALL live in the top level.

Verification
REQ-019 Current channel: x=1000, gain=-262, offset=20 -> scaled_data ch0=16, 2 cycles after in_valid, sat_flag=0.
REQ-020 Voltage channel: x=-1000, gain=-1835, offset=0 -> ch1=28. With x=0, offset=0 -> ch1=0.
REQ-021 Saturation: x=32767, gain=32767, offset=32767 -> output 32767 and sat_flag set. It stays set until sat_clr, and also when sat_clr coincides with a repeat event.
REQ-022 Averaging with AVG_LOG2=2: scaled 10,11,12,14 -> avg_data=11. Scaled -1,-2,-2,-2 -> avg_data=-2. One avg_valid per 4 samples during continuous in_valid.
REQ-023 Apply avg_clr after 2 samples, then feed 4 samples 8,8,8,8 -> avg_data=8 with no earlier avg_valid. Repeat with avg_clr coincident with the 3rd sample -> that sample counts as first of the new window.
REQ-024 Assert rst mid-window and with samples in the pipe -> all outputs are 0 the next cycle, no stray strobe, and the next window starts clean.
